// File: rtl/karatsuba_pkg.sv
// Shared types and widths for the sequential Karatsuba multiplier.
// Operand split, shared-multiplier widths and FSM state encoding.
package karatsuba_pkg;

    localparam int WIDTH  = 32;
    localparam int SPLIT  = 18;
    localparam int HI_W   = WIDTH - SPLIT;
    localparam int SUM_W  = SPLIT + 1;
    localparam int PROD_W = 2 * SUM_W;
    localparam int RES_W  = 2 * WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_P_LO,
        S_P_HI,
        S_P_MID,
        S_FIN,
        S_DONE
    } state_e;

endpackage

// File: rtl/karatsuba_seq_mult_if.sv
// Operand/result handshake bundle for karatsuba_seq_mult.
// master: producer/consumer side; slave: the multiplier.
interface karatsuba_seq_mult_if;
    import karatsuba_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] product;
    logic             busy;

    modport master (
        output in_valid, in1, in2, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, in1, in2, out_ready,
        output in_ready, out_valid, product, busy
    );

endinterface

// File: rtl/shared_mul_unit.sv
// Unsigned SUM_W x SUM_W multiplier with a registered product.
// Ports: clk, rst_n, op_a/op_b (SUM_W), prod (PROD_W, one cycle later).
module shared_mul_unit
    import karatsuba_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SUM_W-1:0]  op_a,
    input  logic [SUM_W-1:0]  op_b,
    output logic [PROD_W-1:0] prod
);

    logic [PROD_W-1:0] prod_d;
    logic [PROD_W-1:0] prod_q;

    always_comb begin
        prod_d = PROD_W'(op_a) * PROD_W'(op_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
        end else begin
            prod_q <= prod_d;
        end
    end

    assign prod = prod_q;

endmodule

// File: rtl/karatsuba_seq_mult.sv
// 32x32 unsigned multiplier sharing one 19x19 unit over three cycles.
// Ports: clk, rst_n, bus (slave: in handshake, out handshake, busy).
module karatsuba_seq_mult
    import karatsuba_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    karatsuba_seq_mult_if.slave  bus
);

    state_e state_q, state_d;

    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [2*SPLIT-1:0]  p_lo_q, p_lo_d;
    logic [2*HI_W-1:0]   p_hi_q, p_hi_d;
    logic [RES_W-1:0]    res_q, res_d;
    logic                rdy_q;

    logic [SUM_W-1:0]    mul_a;
    logic [SUM_W-1:0]    mul_b;
    logic [PROD_W-1:0]   mul_p;
    logic [PROD_W-1:0]   mid;

    // Operand mux: the product selected in state S appears on mul_p
    // during the following state, where it is captured.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        unique case (state_q)
            S_P_LO: begin
                mul_a = SUM_W'(a_q[SPLIT-1:0]);
                mul_b = SUM_W'(b_q[SPLIT-1:0]);
            end
            S_P_HI: begin
                mul_a = SUM_W'(a_q[WIDTH-1:SPLIT]);
                mul_b = SUM_W'(b_q[WIDTH-1:SPLIT]);
            end
            S_P_MID: begin
                mul_a = SUM_W'(a_q[SPLIT-1:0])
                      + SUM_W'(a_q[WIDTH-1:SPLIT]);
                mul_b = SUM_W'(b_q[SPLIT-1:0])
                      + SUM_W'(b_q[WIDTH-1:SPLIT]);
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
    end

    shared_mul_unit u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .op_a  (mul_a),
        .op_b  (mul_b),
        .prod  (mul_p)
    );

    // In FIN the multiplier's output register holds p_sum.
    always_comb begin
        mid = mul_p - PROD_W'(p_hi_q) - PROD_W'(p_lo_q);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_lo_d  = p_lo_q;
        p_hi_d  = p_hi_q;
        res_d   = res_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid && rdy_q) begin
                    a_d     = bus.in1;
                    b_d     = bus.in2;
                    state_d = S_P_LO;
                end
            end
            S_P_LO: begin
                state_d = S_P_HI;
            end
            S_P_HI: begin
                p_lo_d  = mul_p[2*SPLIT-1:0];
                state_d = S_P_MID;
            end
            S_P_MID: begin
                p_hi_d  = mul_p[2*HI_W-1:0];
                state_d = S_FIN;
            end
            S_FIN: begin
                res_d = (RES_W'(p_hi_q) << (2 * SPLIT))
                      + (RES_W'(mid) << SPLIT)
                      + RES_W'(p_lo_q);
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_lo_q  <= '0;
            p_hi_q  <= '0;
            res_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_lo_q  <= p_lo_d;
            p_hi_q  <= p_hi_d;
            res_q   <= res_d;
            rdy_q   <= 1'b1;
        end
    end

    // rdy_q keeps in_ready low until the first clock after reset release.
    assign bus.in_ready  = (state_q == S_IDLE) && rdy_q;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.product   = res_q;

endmodule

// File: doc/karatsuba_seq_mult.md
# karatsuba_seq_mult

Sequential 32×32 unsigned multiplier that time-shares one 19×19 multiplier across the three Karatsuba partial products (low, high, middle) instead of instantiating three DSP-class multipliers. A valid/ready FSM schedules the three products onto the shared unit, then recombines them into a 64-bit result. The block is the low-DSP alternative to the fully combinational Karatsuba multiplier and sits in the same operator slot, with handshakes for pipelined integration.

## Interface
- WIDTH, 32: operand width; result is 2*WIDTH.
- SPLIT, 18: low-half width. Must satisfy SPLIT ≥ WIDTH−SPLIT. High half is WIDTH−SPLIT = 14 bits.
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  operands valid.
- IN_READY  out  1  block can accept operands.
- IN1  in  WIDTH  operand A, unsigned.
- IN2  in  WIDTH  operand B, unsigned.
- OUT_VALID  out  1  OUTPUT holds a completed product.
- OUT_READY  in  1  consumer accepts OUTPUT.
- OUTPUT  out  2*WIDTH  product IN1*IN2.
- BUSY  out  1  FSM is not in IDLE.

## Operation
- Operand split: a_lo=A[SPLIT-1:0], a_hi=A[WIDTH-1:SPLIT]. b_lo and b_hi are split the same way.
- Shared multiplier operands are SPLIT+1 bits wide, zero-extended. The product is 2*(SPLIT+1) bits (38) and is registered inside the sub-module.
- FSM states: IDLE, P_LO, P_HI, P_MID, FIN, DONE.
- IDLE: IN_READY=1. On IN_VALID, register IN1/IN2 and go to P_LO. Operands are ignored in all other states.
- P_LO: multiply a_lo*b_lo and capture p_lo (36 b). Go to P_HI.
- P_HI: multiply a_hi*b_hi and capture p_hi (28 b). Go to P_MID.
- P_MID: multiply (a_lo+a_hi)*(b_lo+b_hi), each sum SPLIT+1 bits. Capture p_sum (38 b). Go to FIN.
- FIN: compute mid = p_sum − p_hi − p_lo. mid is always ≥ 0; compute it at 38 b with no truncation.
  - Register OUTPUT = (p_hi << 2*SPLIT) + (mid << SPLIT) + p_lo, at 64 b. Go to DONE.
- DONE: OUT_VALID=1 and OUTPUT held stable. On OUT_READY, go to IDLE.
- There is no back-to-back acceptance: IN_READY is asserted only in IDLE.

## Timing
- Reset values: IN_READY=0 while RST_N is low, then 1 from the first clock after release (state IDLE). OUT_VALID=0, OUTPUT=0, BUSY=0. All internal registers reset to 0.
- Input handshake at edge k. P_LO, P_HI, P_MID and FIN occupy cycles k..k+3. OUT_VALID rises after edge k+4, giving a fixed latency of 4 cycles from acceptance to OUT_VALID.
- Output handshake at edge m drops OUT_VALID after m, and IN_READY is 1 in the cycle after m. Peak throughput is one product per 6 cycles.
- OUT_READY held low: the block stays in DONE indefinitely. OUTPUT does not change and IN_READY stays 0.
- OUT_READY high before OUT_VALID has no effect.
- IN_VALID deasserted mid-operation has no effect.
- Asserting RST_N low in any state returns the block to IDLE immediately and clears OUTPUT. An in-flight result is discarded and is never presented.
- The shared multiplier is driven by a state-selected mux. Mux select and sub-module inputs are purely combinational from state and operand registers.

## Structure
- Shared package `karatsuba_pkg`:
  - FSM state enum.
  - Localparams derived from WIDTH/SPLIT: HI_W, SUM_W=SPLIT+1, PROD_W=2*SUM_W, RES_W=2*WIDTH.
- One sub-module `shared_mul_unit`: an unsigned SUM_W×SUM_W multiplier with a registered output and a CLK/RST_N interface. It maps to a single DSP-class resource.
- Operand mux, p_lo/p_hi/p_sum registers, recombination adder/subtractor and FSM are in the top level.

## Test plan
- Reset then single op: 7 × 6 → OUTPUT=0x2A with OUT_VALID exactly 4 cycles after acceptance. BUSY=1 for those cycles.
- Max operands: 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE00000001. Checks maximal p_sum and no mid-term truncation.
- Split boundary: 0x00040000 × 0x00040000 → 0x0000001000000000. Also 0x0003FFFF × 0x00000001 → 0x000000000003FFFF.
- Backpressure: hold OUT_READY=0 for 10 cycles after OUT_VALID. OUTPUT must stay stable and IN_READY=0 with IN_VALID held high. Release → OUT_VALID falls, IN_READY=1 next cycle, new operands accepted.
- Reset mid-operation: pulse RST_N low during P_MID. Required: OUT_VALID never asserts for that op, OUTPUT=0, IN_READY=1 after release. The next op, 0x12345678 × 1, returns 0x12345678.
- Random stream: 1000 random operand pairs with random IN_VALID/OUT_READY gaps. Every OUTPUT equals the reference A*B, in order, with no drops or duplicates.
